// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Per-register countdown scoreboard at the ID->EX boundary. Every architectural
// register except x0 has a countdown holding the number of cycles until its
// pending result becomes forwardable. An instruction in ID is held (PC and
// IF/ID frozen, bubble injected into ID/EX) while any source it actually reads
// is still more than one cycle away, or while an older, slower write to the
// same destination is still outstanding (WAW).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears all tracking)
//   issue_valid     instruction present in ID
//   issue_rs        NUM_SRC packed source indices, src0 in the LSBs
//   issue_rs_used   per-source "operand actually read"
//   issue_we        instruction writes rd
//   issue_rd        destination index
//   issue_lat       cycles from issue until result is forwardable (0 acts as 1)
//   flush           kill the instruction in ID this cycle
//   freeze          whole pipeline frozen
//   stall           hazard stall for the instruction in ID
//   load_pc         PC register load enable
//   if_id_load      IF/ID register load enable
//   id_ex_bubble    select nop control word into ID/EX
//   issue_fire      instruction leaves ID this cycle
//   rs_ready        per-source operand-available flag
//   stall_cycles    (HAZARD_SB_PERF_EN only) saturating count of stalled cycles
//   waw_stalls      (HAZARD_SB_PERF_EN only) saturating count of WAW stalls
//
// Optional feature: define HAZARD_SB_PERF_EN to add the two performance
// counters. Without it those ports do not exist.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_SRC   = 2,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic [NUM_SRC*REG_IDX_W-1:0] issue_rs,
    input  logic [NUM_SRC-1:0]           issue_rs_used,
    input  logic                         issue_we,
    input  logic [REG_IDX_W-1:0]         issue_rd,
    input  logic [CNT_W-1:0]             issue_lat,
    input  logic                         flush,
    input  logic                         freeze,
    output logic                         stall,
    output logic                         load_pc,
    output logic                         if_id_load,
    output logic                         id_ex_bubble,
    output logic                         issue_fire,
    output logic [NUM_SRC-1:0]           rs_ready
`ifdef HAZARD_SB_PERF_EN
    ,
    output logic [31:0]                  stall_cycles,
    output logic [31:0]                  waw_stalls
`endif
);

    localparam int NUM_REGS = 2 ** REG_IDX_W;

    // x0 has no entry; lookups of index 0 return zero.
    logic [CNT_W-1:0]     cnt [1:NUM_REGS-1];

    logic [CNT_W-1:0]     eff_lat;
    logic [CNT_W-1:0]     rd_cnt;
    logic [REG_IDX_W-1:0] src_idx;
    logic [CNT_W-1:0]     src_cnt;
    logic                 waw;
    logic                 record;

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    // ---- ID-stage hazard evaluation (combinational) ----
    always_comb begin
        eff_lat  = (issue_lat == '0) ? CNT_W'(1) : issue_lat;
        rd_cnt   = (issue_rd == '0) ? '0 : cnt[issue_rd];
        // A younger write may not finish before an older one to the same rd.
        waw      = issue_we && (issue_rd != '0) && (rd_cnt > eff_lat);
        rs_ready = '0;
        src_idx  = '0;
        src_cnt  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_idx     = issue_rs[i*REG_IDX_W +: REG_IDX_W];
            src_cnt     = (src_idx == '0) ? '0 : cnt[src_idx];
            // A count of 1 means the result is forwardable as the consumer enters EX.
            rs_ready[i] = !issue_rs_used[i] || (src_cnt <= CNT_W'(1));
        end
    end

    assign stall        = issue_valid && !flush && (!(&rs_ready) || waw);
    assign load_pc      = !stall && !freeze;
    assign if_id_load   = !stall && !freeze;
    assign id_ex_bubble = stall && !freeze;
    assign issue_fire   = issue_valid && !stall && !freeze && !flush;
    assign record       = issue_fire && issue_we && (issue_rd != '0);

    // ---- scoreboard update at the ID->EX edge ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else if (!freeze) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                // The issuing write replaces this cycle's decrement of its entry.
                if (record && (issue_rd == REG_IDX_W'(r))) begin
                    cnt[r] <= eff_lat;
                end else begin
                    cnt[r] <= sat_dec(cnt[r]);
                end
            end
        end
    end

`ifdef HAZARD_SB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            waw_stalls   <= '0;
        end else if (!freeze) begin
            if (stall) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (stall && waw) begin
                waw_stalls <= sat_inc(waw_stalls);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed testbench for hazard_scoreboard. Each cycle drives one ID-stage
// instruction shortly after the rising edge and examines the combinational
// outputs on the falling edge. Outputs are grouped as
// {stall, load_pc, if_id_load, id_ex_bubble, issue_fire, rs_ready[1:0]}.
// Define HAZARD_SB_PERF_EN to also exercise the performance counters.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [9:0]  issue_rs;
    logic [1:0]  issue_rs_used;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_lat;
    logic        flush;
    logic        freeze;
    logic        stall;
    logic        load_pc;
    logic        if_id_load;
    logic        id_ex_bubble;
    logic        issue_fire;
    logic [1:0]  rs_ready;
`ifdef HAZARD_SB_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] waw_stalls;
`endif

    logic [6:0]  outs;
    logic [6:0]  exp;
    int          n_checks;
    int          n_fail;

    assign outs = {stall, load_pc, if_id_load, id_ex_bubble, issue_fire, rs_ready};

    hazard_scoreboard #(
        .NUM_SRC   (2),
        .REG_IDX_W (5),
        .CNT_W     (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rs_used (issue_rs_used),
        .issue_we      (issue_we),
        .issue_rd      (issue_rd),
        .issue_lat     (issue_lat),
        .flush         (flush),
        .freeze        (freeze),
        .stall         (stall),
        .load_pc       (load_pc),
        .if_id_load    (if_id_load),
        .id_ex_bubble  (id_ex_bubble),
        .issue_fire    (issue_fire),
        .rs_ready      (rs_ready)
`ifdef HAZARD_SB_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .waw_stalls    (waw_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One ID cycle: the previous cycle's inputs are committed at the rising
    // edge, new inputs are applied, and control returns at the falling edge.
    task automatic cyc(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic we, input logic [4:0] rd,
                       input logic [2:0] lat, input logic fl, input logic fz);
        @(posedge clk);
        #1;
        issue_valid   = v;
        issue_rs      = {rs1, rs0};
        issue_rs_used = used;
        issue_we      = we;
        issue_rd      = rd;
        issue_lat     = lat;
        flush         = fl;
        freeze        = fz;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(1'b1, 5'd5, 5'd6, 2'b11, 1'b1, 5'd5, 3'd7, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL reset_outs: got %b want %b", outs, exp); end
        cyc(1'b1, 5'd5, 5'd6, 2'b11, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0);
        exp = 7'b0_1_1_0_0_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL reset_flush: got %b want %b", outs, exp); end
        idle(1);
        rst = 1'b0;
    endtask

    task automatic test_alu_back_to_back;
        cyc(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd5, 3'd1, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL alu_issue: got %b want %b", outs, exp); end
        cyc(1'b1, 5'd5, 5'd0, 2'b01, 1'b1, 5'd6, 3'd1, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL alu_dep: got %b want %b", outs, exp); end
        cyc(1'b1, 5'd5, 5'd6, 2'b11, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL alu_dep2: got %b want %b", outs, exp); end
        // lat=0 behaves as 1: a pending count of 1 is no WAW hazard for it.
        cyc(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd10, 3'd2, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd10, 3'd0, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL lat0_waw: got %b want %b", outs, exp); end
        idle(8);
    endtask

    task automatic test_load_use;
        cyc(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd7, 3'd2, 1'b0, 1'b0);
        cyc(1'b1, 5'd3, 5'd7, 2'b10, 1'b1, 5'd8, 3'd1, 1'b0, 1'b0);
        exp = 7'b1_0_0_1_0_01;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL load_use_bubble: got %b want %b", outs, exp); end
        cyc(1'b1, 5'd3, 5'd7, 2'b10, 1'b1, 5'd8, 3'd1, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL load_use_fire: got %b want %b", outs, exp); end
        idle(8);
    endtask

    task automatic test_multicycle_freeze;
        logic       fz_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [6:0] exp_tab [6] = '{7'b1_0_0_1_0_10, 7'b1_0_0_1_0_10, 7'b1_0_0_0_0_10,
                                    7'b1_0_0_0_0_10, 7'b1_0_0_1_0_10, 7'b1_0_0_1_0_10};
        cyc(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd3, 3'd5, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, fz_tab[k]);
            n_checks++;
            if (outs !== exp_tab[k]) begin
                n_fail++;
                $display("FAIL mc_stall[%0d]: got %b want %b", k, outs, exp_tab[k]);
            end
        end
        cyc(1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL mc_fire: got %b want %b", outs, exp); end
        // A frozen issue must not be recorded.
        cyc(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd11, 3'd4, 1'b0, 1'b1);
        exp = 7'b0_0_0_0_0_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL freeze_issue: got %b want %b", outs, exp); end
        cyc(1'b1, 5'd11, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL freeze_norecord: got %b want %b", outs, exp); end
        idle(8);
    endtask

    task automatic test_waw;
        cyc(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd9, 3'd5, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd9, 3'd1, 1'b0, 1'b0);
            exp = 7'b1_0_0_1_0_11;
            n_checks++;
            if (outs !== exp) begin n_fail++; $display("FAIL waw_stall[%0d]: got %b want %b", k, outs, exp); end
        end
        cyc(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd9, 3'd1, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL waw_fire: got %b want %b", outs, exp); end
        // Count 1 left; a lat=2 rewrite must replace the decrement with 2.
        cyc(1'b1, 5'd9, 5'd9, 2'b11, 1'b1, 5'd9, 3'd2, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL waw_rewrite: got %b want %b", outs, exp); end
        cyc(1'b1, 5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        exp = 7'b1_0_0_1_0_10;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL waw_override: got %b want %b", outs, exp); end
        cyc(1'b1, 5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL waw_override_fire: got %b want %b", outs, exp); end
        idle(8);
    endtask

    task automatic test_x0_flush;
        cyc(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd0, 3'd4, 1'b0, 1'b0);
        cyc(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd12, 3'd3, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL x0_src: got %b want %b", outs, exp); end
        cyc(1'b1, 5'd12, 5'd12, 2'b11, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        exp = 7'b1_0_0_1_0_00;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL dup_src: got %b want %b", outs, exp); end
        cyc(1'b1, 5'd12, 5'd12, 2'b11, 1'b1, 5'd13, 3'd4, 1'b1, 1'b0);
        exp = 7'b0_1_1_0_0_00;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL flush_outs: got %b want %b", outs, exp); end
        cyc(1'b1, 5'd13, 5'd1, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL flush_norecord: got %b want %b", outs, exp); end
        cyc(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd14, 3'd4, 1'b0, 1'b0);
        cyc(1'b1, 5'd14, 5'd1, 2'b10, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL unused_src: got %b want %b", outs, exp); end
        cyc(1'b1, 5'd1, 5'd14, 2'b10, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        exp = 7'b1_0_0_1_0_01;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL used_src1: got %b want %b", outs, exp); end
        idle(8);
    endtask

    task automatic test_reset_mid;
        cyc(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd4, 3'd4, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        exp = 7'b1_0_0_1_0_10;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL pre_reset_stall: got %b want %b", outs, exp); end
        rst = 1'b1;
        cyc(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL in_reset: got %b want %b", outs, exp); end
        rst = 1'b0;
        cyc(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        exp = 7'b0_1_1_0_1_11;
        n_checks++;
        if (outs !== exp) begin n_fail++; $display("FAIL post_reset: got %b want %b", outs, exp); end
`ifdef HAZARD_SB_PERF_EN
        n_checks++;
        if (stall_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: stall_cycles=%0d want 0", stall_cycles);
        end
`endif
    endtask

`ifdef HAZARD_SB_PERF_EN
    task automatic test_perf;
        cyc(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd7, 3'd3, 1'b0, 1'b0);
        cyc(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
        cyc(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        n_checks++;
        if (stall_cycles !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_stall: stall_cycles=%0d want 2", stall_cycles);
        end
        cyc(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd9, 3'd3, 1'b0, 1'b0);
        cyc(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd9, 3'd1, 1'b0, 1'b0);
        cyc(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd9, 3'd1, 1'b0, 1'b0);
        cyc(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd9, 3'd1, 1'b0, 1'b0);
        n_checks++;
        if (waw_stalls !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_waw: waw_stalls=%0d want 2", waw_stalls);
        end
        n_checks++;
        if (stall_cycles !== 32'd4) begin
            n_fail++;
            $display("FAIL perf_stall_total: stall_cycles=%0d want 4", stall_cycles);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        issue_valid   = 1'b0;
        issue_rs      = '0;
        issue_rs_used = '0;
        issue_we      = 1'b0;
        issue_rd      = '0;
        issue_lat     = '0;
        flush         = 1'b0;
        freeze        = 1'b0;
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_multicycle_freeze();
        test_waw();
        test_x0_flush();
        test_reset_mid();
`ifdef HAZARD_SB_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
